// File: rtl/rom_cache_segment.sv
// rtl/rom_cache_segment.sv - per-ROM read port with a direct-mapped cache of SDRAM words (optional flush: ROM_SEG_FLUSH_EN)
module rom_cache_segment #(
  parameter int          ROM_ADDR_WIDTH = 16,
  parameter int          ROM_DATA_WIDTH = 8,
  parameter logic [23:0] ROM_OFFSET     = 24'h000000,
  parameter int          LINES          = 4
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef ROM_SEG_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic                      cs,
  input  logic                      oe,
  input  logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  output logic [ROM_DATA_WIDTH-1:0] rom_data,
  output logic [22:0]               ctrl_addr,
  output logic                      ctrl_req,
  input  logic                      ctrl_ack,
  input  logic                      ctrl_valid,
  output logic                      ctrl_hit,
  input  logic [31:0]               ctrl_data
);

  // lane bits within a 32-bit word, index bits, word address and tag widths
  localparam int LB  = (ROM_DATA_WIDTH == 8) ? 2 : (ROM_DATA_WIDTH == 16) ? 1 : 0;
  localparam int LBW = (LB > 0) ? LB : 1;
  localparam int IB  = $clog2(LINES);
  localparam int IBW = (IB > 0) ? IB : 1;
  localparam int WA  = ROM_ADDR_WIDTH - LB;
  localparam int TW  = (WA > IB) ? WA - IB : 1;
  localparam logic [22:0] OFF_WORDS = 23'(ROM_OFFSET >> 2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            state_q, next_state;
  logic [31:0]       line_data [LINES];
  logic [TW-1:0]     line_tag  [LINES];
  logic [LINES-1:0]  line_valid;

  logic [WA-1:0]     cur_waddr, lat_waddr;
  logic [IBW-1:0]    cur_idx, lat_idx;
  logic [TW-1:0]     cur_tag, lat_tag;
  logic [LBW-1:0]    cur_lane;
  logic [4:0]        lane_sh;
  logic [31:0]       sel_word;
  logic              start_req, fill_en, bypass, discard;
  logic              flush_i, flush_seen_q;

`ifdef ROM_SEG_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign cur_waddr = WA'(rom_addr >> LB);
  assign cur_idx   = (IB == 0) ? '0 : IBW'(cur_waddr);
  assign cur_tag   = TW'(cur_waddr >> IB);
  assign cur_lane  = (LB == 0) ? '0 : LBW'(rom_addr);
  assign lat_idx   = (IB == 0) ? '0 : IBW'(lat_waddr);
  assign lat_tag   = TW'(lat_waddr >> IB);

  // a fill is thrown away if the cache was flushed while it was outstanding
  assign discard  = flush_seen_q | flush_i;
  assign ctrl_req = (state_q == S_REQ);
  assign ctrl_hit = cs && oe && line_valid[cur_idx] && (line_tag[cur_idx] == cur_tag);
  assign bypass   = (state_q == S_WAIT) && ctrl_valid && cs && (cur_waddr == lat_waddr) && !discard;
  assign sel_word = bypass ? ctrl_data : line_data[cur_idx];
  assign lane_sh  = 5'(int'(cur_lane) * ROM_DATA_WIDTH);
  assign rom_data = ROM_DATA_WIDTH'(sel_word >> lane_sh);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= next_state;
  end

  // next state and per-cycle control strobes
  always_comb begin
    next_state = state_q;
    start_req  = 1'b0;
    fill_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cs && oe && !ctrl_hit) begin
          next_state = S_REQ;
          start_req  = 1'b1;
        end
      end
      S_REQ: begin
        if (ctrl_ack)              next_state = S_WAIT;
        else if (!cs || flush_i)   next_state = S_IDLE;
      end
      S_WAIT: begin
        if (ctrl_valid) begin
          next_state = S_IDLE;
          fill_en    = !discard;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // latch the missing word address and track flushes while it is outstanding
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_addr    <= '0;
      lat_waddr    <= '0;
      flush_seen_q <= 1'b0;
    end else if (start_req) begin
      ctrl_addr    <= 23'(OFF_WORDS + 23'(cur_waddr));
      lat_waddr    <= cur_waddr;
      flush_seen_q <= 1'b0;
    end else if (flush_i) begin
      flush_seen_q <= 1'b1;
    end
  end

  // cache lines: cleared by reset, invalidated by flush, written on a completed fill
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_valid <= '0;
      for (int k = 0; k < LINES; k++) begin
        line_data[k] <= '0;
        line_tag[k]  <= '0;
      end
    end else if (flush_i) begin
      line_valid <= '0;
    end else if (fill_en) begin
      line_valid[lat_idx] <= 1'b1;
      line_data[lat_idx]  <= ctrl_data;
      line_tag[lat_idx]   <= lat_tag;
    end
  end

endmodule

// File: tb/tb_rom_cache_segment.sv
// tb/tb_rom_cache_segment.sv - randomized self-checking bench for rom_cache_segment at 8/16/32-bit widths
module tb_rom_cache_segment;

  localparam int          WID  [3] = '{8, 16, 32};
  localparam logic [23:0] OFFS [3] = '{24'h150000, 24'h000000, 24'h100000};

  logic        clk = 1'b0;
  logic        reset;
  logic        oe;
  logic        cs      [3];
  logic [15:0] rom_addr[3];
  logic        ack     [3];
  logic        cvalid  [3];
  logic [31:0] cdata   [3];
`ifdef ROM_SEG_FLUSH_EN
  logic        flush   [3];
`endif
  logic [31:0] rom_data_a[3];
  logic [22:0] caddr_a   [3];
  logic        creq_a    [3];
  logic        chit_a    [3];

  int checks = 0;
  int errors = 0;

  // reference state: what each instance's cache should hold
  bit          m_valid[3][4];
  int unsigned m_wa   [3][4];
  logic [31:0] m_data [3][4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    logic [WID[g]-1:0] rd;
    rom_cache_segment #(
      .ROM_ADDR_WIDTH(16), .ROM_DATA_WIDTH(WID[g]), .ROM_OFFSET(OFFS[g]), .LINES(4)
    ) dut (
      .clk(clk), .reset(reset),
`ifdef ROM_SEG_FLUSH_EN
      .flush(flush[g]),
`endif
      .cs(cs[g]), .oe(oe), .rom_addr(rom_addr[g]), .rom_data(rd),
      .ctrl_addr(caddr_a[g]), .ctrl_req(creq_a[g]), .ctrl_ack(ack[g]),
      .ctrl_valid(cvalid[g]), .ctrl_hit(chit_a[g]), .ctrl_data(cdata[g])
    );
    assign rom_data_a[g] = 32'(rd);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wa(input int g, input logic [15:0] a);
    return 32'(a) / (32'd32 / 32'(WID[g]));
  endfunction

  function automatic logic [22:0] sd(input int g, input logic [15:0] a);
    return 23'(32'(OFFS[g]) / 32'd4 + wa(g, a));
  endfunction

  function automatic logic [31:0] lane_of(input int g, input logic [15:0] a, input logic [31:0] word);
    int per = 32 / WID[g];
    int ln  = int'(a) % per;
    logic [31:0] v = word >> (ln * WID[g]);
    if (WID[g] < 32) v = v & ((32'd1 << WID[g]) - 32'd1);
    return v;
  endfunction

  function automatic logic [31:0] mem(input logic [22:0] w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h3C5A0F96;
  endfunction

  function automatic bit m_hit(input int g, input logic [15:0] a);
    int i = int'(wa(g, a) % 32'd4);
    return m_valid[g][i] && (m_wa[g][i] == wa(g, a));
  endfunction

  // mode 0 normal, 1 drop cs in REQ, 2 drop cs in WAIT, 3 flush in WAIT
  task automatic access(input int g, input logic [15:0] a, input int mode,
                        input bit use_dat, input logic [31:0] dat_in);
    int i;
    bit hit_e;
    logic [31:0] dat;
    i = int'(wa(g, a) % 32'd4);
    tick();
    cs[g] = 1'b1;
    rom_addr[g] = a;
    #1;
    hit_e = m_hit(g, a);
    check("hit_first", 32'(chit_a[g]), 32'(hit_e));
    check("rdata_first", rom_data_a[g], lane_of(g, a, m_data[g][i]));
    if (hit_e) begin
      tick();
      check("hit_no_req", 32'(creq_a[g]), 32'd0);
      cs[g] = 1'b0;
      return;
    end
    tick();
    check("req_set", 32'(creq_a[g]), 32'd1);
    check("req_addr", 32'(caddr_a[g]), 32'(sd(g, a)));
    if (mode == 1) begin
      cs[g] = 1'b0;
      tick();
      check("req_withdrawn", 32'(creq_a[g]), 32'd0);
      return;
    end
    repeat ($urandom_range(0, 2)) begin
      tick();
      check("req_hold", 32'(creq_a[g]), 32'd1);
    end
    ack[g] = 1'b1;
    tick();
    ack[g] = 1'b0;
    check("req_after_ack", 32'(creq_a[g]), 32'd0);
    if (mode == 2) begin
      cs[g] = 1'b0;
      rom_addr[g] = 16'($urandom);
    end
`ifdef ROM_SEG_FLUSH_EN
    if (mode == 3) begin
      flush[g] = 1'b1;
      tick();
      flush[g] = 1'b0;
      for (int k = 0; k < 4; k++) m_valid[g][k] = 1'b0;
    end
`endif
    repeat ($urandom_range(0, 2)) tick();
    dat = use_dat ? dat_in : mem(sd(g, a));
    cvalid[g] = 1'b1;
    cdata[g] = dat;
    #1;
    if (mode == 0) check("bypass", rom_data_a[g], lane_of(g, a, dat));
    if (mode == 3) check("no_bypass", rom_data_a[g], lane_of(g, a, m_data[g][i]));
    tick();
    cvalid[g] = 1'b0;
    if (mode != 3) begin
      m_valid[g][i] = 1'b1;
      m_wa[g][i]    = wa(g, a);
      m_data[g][i]  = dat;
    end
    if (mode == 2) return;
    #1;
    check("hit_after_fill", 32'(chit_a[g]), 32'(m_hit(g, a)));
    check("rdata_after_fill", rom_data_a[g], lane_of(g, a, m_data[g][i]));
    cs[g] = 1'b0;
  endtask

  task automatic model_clear();
    for (int g = 0; g < 3; g++)
      for (int k = 0; k < 4; k++) begin
        m_valid[g][k] = 1'b0;
        m_wa[g][k]    = 0;
        m_data[g][k]  = '0;
      end
  endtask

  initial begin
    int g, r;
    logic [15:0] a;
    reset = 1'b1;
    oe = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cs[k] = 1'b0; rom_addr[k] = '0; ack[k] = 1'b0; cvalid[k] = 1'b0; cdata[k] = '0;
`ifdef ROM_SEG_FLUSH_EN
      flush[k] = 1'b0;
`endif
    end
    model_clear();
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      check("rst_req", 32'(creq_a[k]), 32'd0);
      check("rst_addr", 32'(caddr_a[k]), 32'd0);
      check("rst_rdata", rom_data_a[k], 32'd0);
      check("rst_hit", 32'(chit_a[k]), 32'd0);
    end
    reset = 1'b0;

    access(0, 16'h0005, 0, 1'b1, 32'hAABBCCDD);
    access(0, 16'h0004, 0, 1'b0, '0);
    access(1, 16'h0003, 0, 1'b1, 32'h12345678);
    access(1, 16'h0002, 0, 1'b0, '0);
    access(2, 16'h0010, 0, 1'b0, '0);
    access(2, 16'h0014, 0, 1'b0, '0);
    access(2, 16'h0010, 0, 1'b0, '0);
    access(1, 16'h0020, 1, 1'b0, '0);
    access(1, 16'h0020, 0, 1'b0, '0);
    access(0, 16'h0040, 2, 1'b0, '0);
    access(0, 16'h0040, 0, 1'b0, '0);

    // reset while a fill is outstanding, then a stray valid
    tick();
    cs[0] = 1'b1; rom_addr[0] = 16'h0080;
    tick();
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0; cs[0] = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid_req", 32'(creq_a[0]), 32'd0);
    tick();
    reset = 1'b0;
    model_clear();
    cvalid[0] = 1'b1; cdata[0] = 32'hDEADBEEF;
    tick();
    cvalid[0] = 1'b0;
    check("rst_stray_req", 32'(creq_a[0]), 32'd0);
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 6; j++) begin
        tick();
        cs[k] = 1'b1; rom_addr[k] = 16'(j * 5);
        #1;
        check("rst_hit_all", 32'(chit_a[k]), 32'd0);
        check("rst_rdata_all", rom_data_a[k], 32'd0);
        cs[k] = 1'b0;
      end

`ifdef ROM_SEG_FLUSH_EN
    access(0, 16'h0000, 0, 1'b0, '0);
    tick();
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    for (int k = 0; k < 4; k++) m_valid[0][k] = 1'b0;
    access(0, 16'h0000, 0, 1'b0, '0);
    access(0, 16'h0010, 3, 1'b0, '0);
    access(0, 16'h0010, 0, 1'b0, '0);
`endif

    for (int n = 0; n < 400; n++) begin
      g = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      if (r == 2) begin
        tick();
        cvalid[g] = 1'b1; cdata[g] = $urandom;
        tick();
        cvalid[g] = 1'b0;
        check("stray_req", 32'(creq_a[g]), 32'd0);
      end else begin
        access(g, a, (r == 0) ? 1 : (r == 1) ? 2 : 0, 1'b0, '0);
      end
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
